// File: rtl/i2s_pkg.sv
// Shared constants and state encoding for the I2S transmitter.
package i2s_pkg;

    localparam int SCLK_DIV_DEF = 32;
    localparam int SLOT_W_DEF   = 32;
    localparam int DATA_W_DEF   = 16;

    localparam int FRAME_BITS = 2 * SLOT_W_DEF;
    localparam int HALF_DIV   = SCLK_DIV_DEF / 2;

    typedef logic [0:0] state_t;
    localparam state_t IDLE = 1'b0;
    localparam state_t RUN  = 1'b1;

endpackage

// File: rtl/i2s_tx_sclk_gen.sv
// Bit-clock divider: owns div_cnt, drives a registered SCLK and flags the
// clk edge on which SCLK falls (div_cnt wrapping to 0).
module i2s_tx_sclk_gen
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = SCLK_DIV_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_run,
    output logic o_sclk,
    output logic o_fall
);
    localparam int DW = $clog2(SCLK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(SCLK_DIV - 1);
    localparam logic [DW-1:0] DIV_HALF = DW'(SCLK_DIV / 2);

    logic [DW-1:0] r_div_cnt;
    logic [DW-1:0] w_div_nxt;
    logic          r_sclk;

    // Out of RUN the divider parks at 0, so SCLK is low and the first
    // SCLK period after entry is a full one.
    always_comb begin
        w_div_nxt = '0;
        if (i_run && (r_div_cnt != DIV_LAST)) begin
            w_div_nxt = r_div_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= '0;
            r_sclk    <= 1'b0;
        end else begin
            r_div_cnt <= w_div_nxt;
            r_sclk    <= (w_div_nxt >= DIV_HALF);
        end
    end

    assign o_sclk = r_sclk;
    assign o_fall = i_run && (r_div_cnt == DIV_LAST);

endmodule

// File: rtl/i2s_tx.sv
// I2S serializer: latches a left/right sample pair per frame and shifts it
// out MSB first with the standard one-bit delay after each LRCLK change.
//   state | meaning
//   IDLE  | outputs parked low, waiting for en
//   RUN   | framing active; stops only at a frame end with en low
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int SCLK_DIV = SCLK_DIV_DEF,
    parameter int SLOT_W   = SLOT_W_DEF,
    parameter int DATA_W   = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [DATA_W-1:0] lft_in,
    input  logic [DATA_W-1:0] rht_in,
    output logic              SCLK,
    output logic              LRCLK,
    output logic              SDout,
    output logic              smpl_ld,
    output logic              busy
);
    localparam int FRAME_N = 2 * SLOT_W;
    localparam int BW      = $clog2(FRAME_N);
    localparam logic [BW-1:0] BIT_LAST  = BW'(FRAME_N - 1);
    localparam logic [BW-1:0] RHT_FIRST = BW'(SLOT_W);

    state_t            r_state;
    logic [BW-1:0]     r_bit_cnt;
    logic [DATA_W-1:0] r_lft_sh;
    logic [DATA_W-1:0] r_rht_sh;
    logic              r_lrclk;
    logic              r_sdout;
    logic              r_smpl_ld;

    logic              w_fall;
    logic              w_frame_end;
    logic              w_load;
    logic [BW-1:0]     w_bit_nxt;
    logic              w_lr_nxt;
    logic              w_sd_nxt;

    i2s_tx_sclk_gen #(
        .SCLK_DIV (SCLK_DIV)
    ) u_sclk_gen (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_run  (r_state == RUN),
        .o_sclk (SCLK),
        .o_fall (w_fall)
    );

    assign w_frame_end = w_fall && (r_bit_cnt == BIT_LAST);
    assign w_load      = en && ((r_state == IDLE) || ((r_state == RUN) && w_frame_end));
    assign w_bit_nxt   = (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
    assign w_lr_nxt    = (w_bit_nxt >= RHT_FIRST);

    // Slot k carries bit DATA_W-k of its channel; slot 0 of each half and
    // the padding slots stay low. Slot 0 never reads the shadow, so a
    // reload on the same edge cannot leak into the data.
    always_comb begin
        w_sd_nxt = 1'b0;
        for (int k = 1; k <= DATA_W; k++) begin
            if (w_bit_nxt == BW'(k)) begin
                w_sd_nxt = r_lft_sh[DATA_W-k];
            end
            if (w_bit_nxt == BW'(SLOT_W + k)) begin
                w_sd_nxt = r_rht_sh[DATA_W-k];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_bit_cnt <= '0;
            r_lft_sh  <= '0;
            r_rht_sh  <= '0;
            r_lrclk   <= 1'b0;
            r_sdout   <= 1'b0;
            r_smpl_ld <= 1'b0;
        end else begin
            r_smpl_ld <= w_load;
            if (w_load) begin
                r_lft_sh <= lft_in;
                r_rht_sh <= rht_in;
            end
            case (r_state)
                IDLE: begin
                    r_bit_cnt <= '0;
                    r_lrclk   <= 1'b0;
                    r_sdout   <= 1'b0;
                    if (en) begin
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_frame_end && !en) begin
                        r_state   <= IDLE;
                        r_bit_cnt <= '0;
                        r_lrclk   <= 1'b0;
                        r_sdout   <= 1'b0;
                    end else if (w_fall) begin
                        r_bit_cnt <= w_bit_nxt;
                        r_lrclk   <= w_lr_nxt;
                        r_sdout   <= w_sd_nxt;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign LRCLK   = r_lrclk;
    assign SDout   = r_sdout;
    assign smpl_ld = r_smpl_ld;
    assign busy    = (r_state == RUN);

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx with SCLK_DIV=8, SLOT_W=32, DATA_W=16 (512 clk frame).
module tb_i2s_tx;

    localparam int SCLK_DIV = 8;
    localparam int SLOT_W   = 32;
    localparam int DATA_W   = 16;
    localparam logic [63:0] DATA_MASK = 64'h0001_FFFE_0001_FFFE;
    localparam logic [63:0] LR_EXP    = 64'hFFFF_FFFF_0000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] lft_in = '0;
    logic [15:0] rht_in = '0;
    logic        SCLK, LRCLK, SDout, smpl_ld, busy;

    int n_vec = 0;
    int n_err = 0;

    i2s_tx #(
        .SCLK_DIV (SCLK_DIV),
        .SLOT_W   (SLOT_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .lft_in  (lft_in),
        .rht_in  (rht_in),
        .SCLK    (SCLK),
        .LRCLK   (LRCLK),
        .SDout   (SDout),
        .smpl_ld (smpl_ld),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_rise(output bit ok);
        bit p;
        p  = SCLK;
        ok = 1'b0;
        for (int i = 0; i < 4 * SCLK_DIV; i++) begin
            @(negedge clk);
            if (!p && SCLK) begin
                ok = 1'b1;
                break;
            end
            p = SCLK;
        end
    endtask

    // Samples SDout/LRCLK at each of the next 64 SCLK rises (slot i -> bit i).
    task automatic capture_frame(output logic [63:0] sd, output logic [63:0] lr, output int tmo);
        bit ok;
        tmo = 0;
        sd  = '0;
        lr  = '0;
        for (int i = 0; i < 64; i++) begin
            wait_rise(ok);
            if (!ok) tmo++;
            sd[i] = SDout;
            lr[i] = LRCLK;
        end
    endtask

    task automatic wait_smpl(output int n);
        n = 0;
        while (n < 1200) begin
            @(negedge clk);
            n++;
            if (smpl_ld) return;
        end
        n = -1;
    endtask

    function automatic logic [15:0] word_at(input logic [63:0] sd, input int first);
        logic [15:0] w;
        for (int k = 0; k < 16; k++) w[15-k] = sd[first+k];
        return w;
    endfunction

    task automatic test_reset;
        rst_n = 1'b0;
        en    = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({SCLK, LRCLK, SDout, smpl_ld, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b want 00000", {SCLK, LRCLK, SDout, smpl_ld, busy});
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        n_vec++;
        if ({SCLK, LRCLK, SDout, smpl_ld, busy} !== 5'b0) begin
            n_err++;
            $display("FAIL idle_hold: got %b want 00000", {SCLK, LRCLK, SDout, smpl_ld, busy});
        end
    endtask

    task automatic test_basic;
        logic [63:0] sd, lr;
        int tmo;
        lft_in = 16'hA5C3;
        rht_in = 16'h1234;
        en     = 1'b1;
        fork
            capture_frame(sd, lr, tmo);
            begin
                @(negedge clk);
                n_vec++;
                if ({smpl_ld, busy, LRCLK} !== 3'b110) begin
                    n_err++;
                    $display("FAIL basic_entry: smpl_ld,busy,lrclk got %b want 110", {smpl_ld, busy, LRCLK});
                end
                @(negedge clk);
                n_vec++;
                if (smpl_ld !== 1'b0) begin
                    n_err++;
                    $display("FAIL basic_smpl_width: got %b want 0", smpl_ld);
                end
            end
        join
        n_vec++;
        if (tmo !== 0) begin n_err++; $display("FAIL basic_timeout: got %0d want 0", tmo); end
        n_vec++;
        if (word_at(sd, 1) !== 16'hA5C3) begin
            n_err++; $display("FAIL basic_left: got %h want a5c3", word_at(sd, 1));
        end
        n_vec++;
        if (word_at(sd, 33) !== 16'h1234) begin
            n_err++; $display("FAIL basic_right: got %h want 1234", word_at(sd, 33));
        end
        n_vec++;
        if ((sd & ~DATA_MASK) !== 64'h0) begin
            n_err++; $display("FAIL basic_padding: got %h want 0", sd & ~DATA_MASK);
        end
        n_vec++;
        if (lr !== LR_EXP) begin
            n_err++; $display("FAIL basic_lrclk: got %h want %h", lr, LR_EXP);
        end
    endtask

    task automatic test_timing;
        int rises, sclk_hi, lr_hi, bad_chg, lr_edges, last_rise, last_lr_rise, lr_per;
        int min_p, max_p, hi_run, min_hi, max_hi;
        bit ps, pl, pd, run_ok;
        rises = 0; sclk_hi = 0; lr_hi = 0; bad_chg = 0; lr_edges = 0;
        last_rise = -1; last_lr_rise = -1; lr_per = 0;
        min_p = 1000; max_p = 0; hi_run = 0; min_hi = 1000; max_hi = 0; run_ok = 1'b0;
        ps = SCLK; pl = LRCLK; pd = SDout;
        for (int t = 0; t < 1024; t++) begin
            @(negedge clk);
            if (SCLK) sclk_hi++;
            if (LRCLK) lr_hi++;
            if ((LRCLK !== pl || SDout !== pd) && !(ps && !SCLK)) bad_chg++;
            if (LRCLK !== pl) lr_edges++;
            if (!pl && LRCLK) begin
                if (last_lr_rise >= 0) lr_per = t - last_lr_rise;
                last_lr_rise = t;
            end
            if (!ps && SCLK) begin
                rises++;
                if (last_rise >= 0) begin
                    if (t - last_rise < min_p) min_p = t - last_rise;
                    if (t - last_rise > max_p) max_p = t - last_rise;
                end
                last_rise = t;
                hi_run = 0;
                run_ok = 1'b1;
            end
            if (SCLK) hi_run++;
            else if (ps && run_ok) begin
                if (hi_run < min_hi) min_hi = hi_run;
                if (hi_run > max_hi) max_hi = hi_run;
            end
            ps = SCLK; pl = LRCLK; pd = SDout;
        end
        n_vec++;
        if (rises !== 128) begin n_err++; $display("FAIL timing_rises: got %0d want 128", rises); end
        n_vec++;
        if (min_p !== 8 || max_p !== 8) begin
            n_err++; $display("FAIL timing_sclk_period: got %0d..%0d want 8", min_p, max_p);
        end
        n_vec++;
        if (min_hi !== 4 || max_hi !== 4) begin
            n_err++; $display("FAIL timing_sclk_high: got %0d..%0d want 4", min_hi, max_hi);
        end
        n_vec++;
        if (sclk_hi !== 512) begin n_err++; $display("FAIL timing_sclk_duty: got %0d want 512", sclk_hi); end
        n_vec++;
        if (lr_hi !== 512 || lr_edges !== 4) begin
            n_err++; $display("FAIL timing_lrclk_duty: high %0d edges %0d want 512 4", lr_hi, lr_edges);
        end
        n_vec++;
        if (lr_per !== 512) begin n_err++; $display("FAIL timing_lrclk_period: got %0d want 512", lr_per); end
        n_vec++;
        if (bad_chg !== 0) begin n_err++; $display("FAIL timing_change_off_fall: got %0d want 0", bad_chg); end
    endtask

    task automatic test_reload;
        logic [63:0] sd, lr;
        int tmo, n;
        wait_smpl(n);
        n_vec++;
        if (n <= 0) begin n_err++; $display("FAIL reload_align: got %0d want >0", n); end
        fork
            capture_frame(sd, lr, tmo);
            begin
                repeat (100) @(negedge clk);
                lft_in = 16'h8001;
            end
        join
        n_vec++;
        if (word_at(sd, 1) !== 16'hA5C3 || tmo !== 0) begin
            n_err++; $display("FAIL reload_old_left: got %h tmo %0d want a5c3 0", word_at(sd, 1), tmo);
        end
        n_vec++;
        if (word_at(sd, 33) !== 16'h1234) begin
            n_err++; $display("FAIL reload_old_right: got %h want 1234", word_at(sd, 33));
        end
        wait_smpl(n);
        n_vec++;
        if (n !== 4) begin n_err++; $display("FAIL reload_boundary: got %0d want 4", n); end
        fork
            capture_frame(sd, lr, tmo);
            wait_smpl(n);
        join
        n_vec++;
        if (n !== 512) begin n_err++; $display("FAIL reload_smpl_period: got %0d want 512", n); end
        n_vec++;
        if (word_at(sd, 1) !== 16'h8001 || tmo !== 0) begin
            n_err++; $display("FAIL reload_new_left: got %h tmo %0d want 8001 0", word_at(sd, 1), tmo);
        end
        n_vec++;
        if ((sd & ~DATA_MASK) !== 64'h0 || lr !== LR_EXP) begin
            n_err++; $display("FAIL reload_frame_shape: pad %h lr %h", sd & ~DATA_MASK, lr);
        end
        @(negedge clk);
        n_vec++;
        if (smpl_ld !== 1'b0) begin n_err++; $display("FAIL reload_smpl_width: got %b want 0", smpl_ld); end
    endtask

    task automatic test_stop;
        logic [63:0] sd, lr;
        int tmo, n, hi_cnt;
        wait_smpl(n);
        n_vec++;
        if (n <= 0) begin n_err++; $display("FAIL stop_align: got %0d want >0", n); end
        fork
            capture_frame(sd, lr, tmo);
            begin
                repeat (80) @(negedge clk);
                en = 1'b0;
            end
        join
        n_vec++;
        if (word_at(sd, 1) !== 16'h8001 || word_at(sd, 33) !== 16'h1234 || tmo !== 0) begin
            n_err++;
            $display("FAIL stop_frame_completes: got %h %h tmo %0d want 8001 1234 0",
                     word_at(sd, 1), word_at(sd, 33), tmo);
        end
        n_vec++;
        if (lr !== LR_EXP || busy !== 1'b1) begin
            n_err++; $display("FAIL stop_late_frame: lr %h busy %b", lr, busy);
        end
        repeat (4) @(negedge clk);
        n_vec++;
        if ({busy, SCLK, LRCLK, SDout, smpl_ld} !== 5'b0) begin
            n_err++; $display("FAIL stop_idle_outputs: got %b want 00000", {busy, SCLK, LRCLK, SDout, smpl_ld});
        end
        hi_cnt = 0;
        repeat (600) begin
            @(negedge clk);
            if (smpl_ld || SCLK || busy) hi_cnt++;
        end
        n_vec++;
        if (hi_cnt !== 0) begin n_err++; $display("FAIL stop_quiet: got %0d active cycles want 0", hi_cnt); end
    endtask

    task automatic test_restart_extremes;
        logic [63:0] sd, lr;
        int tmo;
        lft_in = 16'h7FFF;
        rht_in = 16'h8000;
        en     = 1'b1;
        fork
            capture_frame(sd, lr, tmo);
            begin
                @(negedge clk);
                n_vec++;
                if ({smpl_ld, busy, LRCLK} !== 3'b110) begin
                    n_err++;
                    $display("FAIL restart_entry: smpl_ld,busy,lrclk got %b want 110", {smpl_ld, busy, LRCLK});
                end
                @(negedge clk);
                n_vec++;
                if (smpl_ld !== 1'b0) begin
                    n_err++; $display("FAIL restart_smpl_width: got %b want 0", smpl_ld);
                end
            end
        join
        n_vec++;
        if (sd !== 64'h0000_0002_0001_FFFC || tmo !== 0) begin
            n_err++; $display("FAIL extremes_data: got %h tmo %0d want 000000020001fffc 0", sd, tmo);
        end
        n_vec++;
        if (lr !== LR_EXP) begin n_err++; $display("FAIL extremes_lrclk: got %h want %h", lr, LR_EXP); end
    endtask

    task automatic test_reset_mid;
        logic [63:0] sd, lr;
        int tmo, n;
        lft_in = 16'h0F0F;
        rht_in = 16'hFFFF;
        wait_smpl(n);
        n_vec++;
        if (n <= 0) begin n_err++; $display("FAIL rstmid_align: got %0d want >0", n); end
        repeat (324) @(negedge clk);
        n_vec++;
        if ({SCLK, LRCLK, SDout, busy} !== 4'b1111) begin
            n_err++; $display("FAIL rstmid_pre: sclk,lr,sd,busy got %b want 1111", {SCLK, LRCLK, SDout, busy});
        end
        #1 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({SCLK, LRCLK, SDout, smpl_ld, busy} !== 5'b0) begin
            n_err++; $display("FAIL rstmid_async: got %b want 00000", {SCLK, LRCLK, SDout, smpl_ld, busy});
        end
        repeat (3) @(negedge clk);
        lft_in = 16'h1357;
        rht_in = 16'h2468;
        rst_n  = 1'b1;
        fork
            capture_frame(sd, lr, tmo);
            begin
                @(negedge clk);
                n_vec++;
                if ({smpl_ld, busy} !== 2'b11) begin
                    n_err++; $display("FAIL rstmid_restart: smpl_ld,busy got %b want 11", {smpl_ld, busy});
                end
            end
        join
        n_vec++;
        if (word_at(sd, 1) !== 16'h1357 || word_at(sd, 33) !== 16'h2468 || tmo !== 0) begin
            n_err++;
            $display("FAIL rstmid_fresh_frame: got %h %h tmo %0d want 1357 2468 0",
                     word_at(sd, 1), word_at(sd, 33), tmo);
        end
        n_vec++;
        if (lr !== LR_EXP || (sd & ~DATA_MASK) !== 64'h0) begin
            n_err++; $display("FAIL rstmid_frame_shape: lr %h pad %h", lr, sd & ~DATA_MASK);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_timing();
        test_reload();
        test_stop();
        test_restart_extremes();
        test_reset_mid();
        en = 1'b0;
        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
